// File: rtl/rvfi_order_sequencer_if.sv
// Retirement record bundle: in_* from the out-of-order core, rvfi_* in program order to consumers.
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

interface rvfi_order_sequencer_if #(
   parameter int DEPTH = 8,
   parameter int XLEN  = `RISCV_FORMAL_XLEN
);
   localparam int PW = $clog2(DEPTH) + 1;

   logic            in_valid;
   logic [7:0]      in_order;
   logic [31:0]     in_insn;
   logic [4:0]      in_rs1_addr;
   logic [XLEN-1:0] in_rs1_rdata;
   logic [4:0]      in_rs2_addr;
   logic [XLEN-1:0] in_rs2_rdata;
   logic [4:0]      in_rd_addr;
   logic [XLEN-1:0] in_post_rd;
   logic            in_trap;

   logic            rvfi_valid;
   logic [7:0]      rvfi_order;
   logic [31:0]     rvfi_insn;
   logic [4:0]      rvfi_rs1_addr;
   logic [XLEN-1:0] rvfi_rs1_rdata;
   logic [4:0]      rvfi_rs2_addr;
   logic [XLEN-1:0] rvfi_rs2_rdata;
   logic [4:0]      rvfi_rd_addr;
   logic [XLEN-1:0] rvfi_post_rd;
   logic            rvfi_trap;
   logic [PW-1:0]   pending;
   logic            err_dup;
   logic            err_window;

   modport slave (
      input  in_valid, in_order, in_insn, in_rs1_addr, in_rs1_rdata, in_rs2_addr,
             in_rs2_rdata, in_rd_addr, in_post_rd, in_trap,
      output rvfi_valid, rvfi_order, rvfi_insn, rvfi_rs1_addr, rvfi_rs1_rdata, rvfi_rs2_addr,
             rvfi_rs2_rdata, rvfi_rd_addr, rvfi_post_rd, rvfi_trap, pending, err_dup, err_window
   );

   modport master (
      output in_valid, in_order, in_insn, in_rs1_addr, in_rs1_rdata, in_rs2_addr,
             in_rs2_rdata, in_rd_addr, in_post_rd, in_trap,
      input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_rs1_addr, rvfi_rs1_rdata, rvfi_rs2_addr,
             rvfi_rs2_rdata, rvfi_rd_addr, rvfi_post_rd, rvfi_trap, pending, err_dup, err_window
   );
endinterface

// File: rtl/rvfi_order_sequencer.sv
// RVFI retirement re-sequencer: buffers records by order tag in a DEPTH-slot window and
// emits them in ascending order (mod 256), bypassing the buffer when the head record arrives.
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

module rvfi_order_sequencer #(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   rvfi_order_sequencer_if.slave  bus
);
   localparam int XLEN = `RISCV_FORMAL_XLEN;
   localparam int AW   = $clog2(DEPTH);
   localparam int PW   = AW + 1;

   typedef struct packed {
      logic [31:0]     insn;
      logic [4:0]      rs1_addr;
      logic [XLEN-1:0] rs1_rdata;
      logic [4:0]      rs2_addr;
      logic [XLEN-1:0] rs2_rdata;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] post_rd;
      logic            trap;
   } payload_t;

   logic [7:0]       r_head;
   logic [DEPTH-1:0] r_occ;
   payload_t         r_ram [DEPTH];
   logic [PW-1:0]    r_pending;
   logic             r_err_dup;
   logic             r_err_window;
   logic             r_valid;
   logic [7:0]       r_order;
   payload_t         r_out;

   payload_t         w_in;
   logic [7:0]       w_delta;
   logic [AW-1:0]    w_slot;
   logic [AW-1:0]    w_hslot;
   logic             w_in_win;
   logic             w_dup;
   logic             w_acc;
   logic             w_emit_ram;
   logic             w_bypass;
   logic             w_store;

   assign w_in = '{insn: bus.in_insn, rs1_addr: bus.in_rs1_addr, rs1_rdata: bus.in_rs1_rdata,
                   rs2_addr: bus.in_rs2_addr, rs2_rdata: bus.in_rs2_rdata,
                   rd_addr: bus.in_rd_addr, post_rd: bus.in_post_rd, trap: bus.in_trap};

   // Modular distance from head makes the window check wrap-safe across 255->0.
   assign w_delta    = bus.in_order - r_head;
   assign w_slot     = bus.in_order[AW-1:0];
   assign w_hslot    = r_head[AW-1:0];
   assign w_in_win   = (w_delta < 8'(DEPTH));
   assign w_dup      = bus.in_valid && w_in_win && r_occ[w_slot];
   assign w_acc      = bus.in_valid && w_in_win && !r_occ[w_slot];
   assign w_emit_ram = r_occ[w_hslot];
   assign w_bypass   = !w_emit_ram && w_acc && (w_delta == 8'd0);
   assign w_store    = w_acc && !w_bypass;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head       <= '0;
         r_occ        <= '0;
         r_pending    <= '0;
         r_err_dup    <= 1'b0;
         r_err_window <= 1'b0;
         r_valid      <= 1'b0;
         r_order      <= '0;
         r_out        <= '0;
      end else begin
         if (bus.in_valid && !w_in_win) r_err_window <= 1'b1;
         if (w_dup)                     r_err_dup    <= 1'b1;

         r_valid <= w_emit_ram || w_bypass;
         if (w_emit_ram) begin
            r_out   <= r_ram[w_hslot];
            r_order <= r_head;
            r_head  <= r_head + 8'd1;
         end else if (w_bypass) begin
            r_out   <= w_in;
            r_order <= r_head;
            r_head  <= r_head + 8'd1;
         end

         // A stored slot can never equal the emitted head slot, so clear and set never collide.
         if (w_emit_ram) r_occ[w_hslot] <= 1'b0;
         if (w_store)    r_occ[w_slot]  <= 1'b1;

         if (w_store && !w_emit_ram)      r_pending <= r_pending + PW'(1);
         else if (!w_store && w_emit_ram) r_pending <= r_pending - PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_store) r_ram[w_slot] <= w_in;
   end

   assign bus.rvfi_valid     = r_valid;
   assign bus.rvfi_order     = r_order;
   assign bus.rvfi_insn      = r_out.insn;
   assign bus.rvfi_rs1_addr  = r_out.rs1_addr;
   assign bus.rvfi_rs1_rdata = r_out.rs1_rdata;
   assign bus.rvfi_rs2_addr  = r_out.rs2_addr;
   assign bus.rvfi_rs2_rdata = r_out.rs2_rdata;
   assign bus.rvfi_rd_addr   = r_out.rd_addr;
   assign bus.rvfi_post_rd   = r_out.post_rd;
   assign bus.rvfi_trap      = r_out.trap;
   assign bus.pending        = r_pending;
   assign bus.err_dup        = r_err_dup;
   assign bus.err_window     = r_err_window;
endmodule
